// File: rtl/core_config_pkg.sv
// ============================================================================
// Module      : core_config
// Description : Shared core constants and the dcache write-bridge state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_config;

    localparam int         DCACHELINE_WIDTH = 128;
    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } bridge_state_e;

endpackage

`default_nettype wire

// File: rtl/dcache_axi_wbridge.sv
// ============================================================================
// Module      : dcache_axi_wbridge
// Description : Issues one dcache line write as a single AXI4 INCR burst.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_axi_wbridge
    import core_config::*;
#(
    parameter int LINE_WIDTH = DCACHELINE_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int AXI_ID     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wen_i,
    input  logic [LINE_WIDTH-1:0]   wdata_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    output logic                    req_accept_o,
    output logic                    bvalid_o,
    output logic                    berr_o,
    output logic [3:0]              awid_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic [7:0]              awlen_o,
    output logic [2:0]              awsize_o,
    output logic [1:0]              awburst_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wlast_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic [1:0]              bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o
);

    localparam int BEATS = LINE_WIDTH / DATA_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int SIZE  = $clog2(DATA_WIDTH / 8);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

    bridge_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    accept_q, accept_d;
    logic                    bvalid_q, bvalid_d;
    logic                    berr_q, berr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            bvalid_q <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
            bvalid_q <= bvalid_d;
            berr_q   <= berr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        bvalid_d = 1'b0;
        berr_d   = 1'b0;
        case (state_q)
            // The FIFO may still hold wen_i high while bvalid_o is out; a
            // capture here would duplicate the line it is about to pop.
            ST_IDLE: begin
                if (wen_i && !bvalid_q) begin
                    addr_d   = awaddr_i & LINE_MASK;
                    shift_d  = wdata_i;
                    accept_d = 1'b1;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (awready_i) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (wready_i) begin
                    shift_d = shift_q >> DATA_WIDTH;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RESP: begin
                if (bvalid_i) begin
                    bvalid_d = 1'b1;
                    berr_d   = (bresp_i != AXI_RESP_OKAY);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_accept_o = accept_q;
    assign bvalid_o     = bvalid_q;
    assign berr_o       = berr_q;
    assign awid_o       = 4'(AXI_ID);
    assign awaddr_o     = addr_q;
    assign awlen_o      = 8'(BEATS - 1);
    assign awsize_o     = 3'(SIZE);
    assign awburst_o    = AXI_BURST_INCR;
    assign awvalid_o    = (state_q == ST_ADDR);
    assign wdata_o      = shift_q[DATA_WIDTH-1:0];
    assign wstrb_o      = '1;
    assign wvalid_o     = (state_q == ST_DATA);
    assign wlast_o      = (state_q == ST_DATA) && (cnt_q == LAST_BEAT);
    assign bready_o     = (state_q == ST_RESP);

endmodule

`default_nettype wire

// File: tb/tb_dcache_axi_wbridge.sv
// ============================================================================
// Module      : tb_dcache_axi_wbridge
// Description : Self-checking bench for dcache_axi_wbridge with a line model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_axi_wbridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         wen_i;
    logic [127:0] wdata_i;
    logic [31:0]  awaddr_i;
    logic         req_accept_o, bvalid_o, berr_o;
    logic [3:0]   awid_o;
    logic [31:0]  awaddr_o;
    logic [7:0]   awlen_o;
    logic [2:0]   awsize_o;
    logic [1:0]   awburst_o;
    logic         awvalid_o, awready_i;
    logic [31:0]  wdata_o;
    logic [3:0]   wstrb_o;
    logic         wlast_o, wvalid_o, wready_i;
    logic [1:0]   bresp_i;
    logic         bvalid_i, bready_o;

    dcache_axi_wbridge dut (
        .clk(clk), .rst(rst), .wen_i(wen_i), .wdata_i(wdata_i), .awaddr_i(awaddr_i),
        .req_accept_o(req_accept_o), .bvalid_o(bvalid_o), .berr_o(berr_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
        .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
        .wready_i(wready_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observations of the most recent transaction
    int          o_t0, o_accepts, o_accept_abs, o_bvalid_abs, o_first_beat_rel;
    int          o_wlast_rel, o_wlast_cnt, o_wlast_beat, o_aw_cycles;
    logic [31:0] o_beats[$];
    logic [31:0] o_awaddr;
    logic [7:0]  o_awlen;
    logic        o_err;
    bit          o_aw_unstable, o_early_w, o_w_unstable, o_timeout;
    logic [6:0]  o_post_rst;

    // w_mode: 0 = always ready, 1 = alternate starting low, 2 = random
    task automatic run_txn(input logic [31:0] addr, input logic [127:0] data,
                           input logic [1:0] resp, input int aw_stall, input int w_mode,
                           input int b_stall, input bit hold_wen, input int rst_beat);
        int          aw_wait = 0, b_wait = 0;
        bit          aw_hs = 0, prev_aw_stall = 0, prev_w_stall = 0, phase = 0, done = 0;
        logic [31:0] prev_wd = '0, prev_aa = '0;
        logic        prev_wl = 1'b0;
        o_accepts = 0; o_accept_abs = -1; o_bvalid_abs = -1; o_first_beat_rel = -1;
        o_wlast_rel = -1; o_wlast_cnt = 0; o_wlast_beat = -1; o_aw_cycles = 0;
        o_beats.delete(); o_awaddr = 'x; o_awlen = 'x; o_err = 1'bx;
        o_aw_unstable = 0; o_early_w = 0; o_w_unstable = 0; o_timeout = 0;
        o_post_rst = 'x;
        @(negedge clk);
        wen_i = 1'b1; awaddr_i = addr; wdata_i = data; o_t0 = cyc;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (!hold_wen) wen_i = 1'b0;
            awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = resp;
            if (req_accept_o) begin o_accepts++; o_accept_abs = cyc; end
            if (prev_aw_stall && (!awvalid_o || awaddr_o !== prev_aa)) o_aw_unstable = 1;
            if (prev_w_stall && (!wvalid_o || wdata_o !== prev_wd || wlast_o !== prev_wl))
                o_w_unstable = 1;
            prev_aw_stall = 0;
            prev_w_stall  = 0;
            if (wvalid_o) begin
                if (!aw_hs) o_early_w = 1;
                if (rst_beat > 0 && o_beats.size() == rst_beat) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    o_post_rst = {req_accept_o, bvalid_o, berr_o, awvalid_o,
                                  wvalid_o, wlast_o, bready_o};
                    done = 1;
                end else begin
                    case (w_mode)
                        0:       wready_i = 1'b1;
                        1:       begin wready_i = phase; phase = !phase; end
                        default: wready_i = 1'($urandom_range(0, 1));
                    endcase
                    if (wready_i) begin
                        if (o_beats.size() == 0) o_first_beat_rel = cyc - o_t0;
                        o_beats.push_back(wdata_o);
                        if (wlast_o) begin
                            o_wlast_cnt++;
                            o_wlast_beat = o_beats.size();
                            o_wlast_rel  = cyc - o_t0;
                        end
                    end
                    prev_w_stall = !wready_i; prev_wd = wdata_o; prev_wl = wlast_o;
                end
            end
            if (awvalid_o) begin
                if (o_aw_cycles == 0) begin o_awaddr = awaddr_o; o_awlen = awlen_o; end
                o_aw_cycles++;
                awready_i = (aw_wait >= aw_stall);
                aw_wait++;
                if (awready_i) aw_hs = 1;
                prev_aw_stall = !awready_i; prev_aa = awaddr_o;
            end
            if (bready_o) begin
                bvalid_i = (b_wait >= b_stall);
                b_wait++;
            end
            if (bvalid_o) begin o_bvalid_abs = cyc; o_err = berr_o; done = 1; end
        end
        if (!done) o_timeout = 1;
        awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
        if (!hold_wen) wen_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({req_accept_o, bvalid_o, berr_o, awvalid_o, wvalid_o, wlast_o, bready_o} !== 7'b0) begin n_fail++; $display("FAIL reset_outputs: got %b expected 0000000", {req_accept_o, bvalid_o, berr_o, awvalid_o, wvalid_o, wlast_o, bready_o}); end
        n_cmp++; if (awid_o !== 4'd1 || awlen_o !== 8'd3 || awsize_o !== 3'd2 || awburst_o !== 2'b01 || wstrb_o !== 4'hF) begin n_fail++; $display("FAIL reset_consts: got id=%h len=%h size=%h burst=%h strb=%h expected 1/3/2/1/f", awid_o, awlen_o, awsize_o, awburst_o, wstrb_o); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({req_accept_o, awvalid_o, wvalid_o, bready_o} !== 4'b0) begin n_fail++; $display("FAIL idle_no_req: got %b expected 0000", {req_accept_o, awvalid_o, wvalid_o, bready_o}); end
    endtask

    task automatic test_basic();
        logic [127:0] d = 128'h44444444_33333333_22222222_11111111;
        run_txn(32'h1000_0024, d, 2'b00, 0, 0, 0, 1'b0, 0);
        n_cmp++; if (o_accept_abs - o_t0 !== 1) begin n_fail++; $display("FAIL basic_accept_cycle: got %0d expected 1", o_accept_abs - o_t0); end
        n_cmp++; if (o_awaddr !== 32'h1000_0020) begin n_fail++; $display("FAIL basic_awaddr: got %h expected 10000020", o_awaddr); end
        n_cmp++; if (o_awlen !== 8'd3) begin n_fail++; $display("FAIL basic_awlen: got %0d expected 3", o_awlen); end
        n_cmp++; if (o_beats.size() !== 4) begin n_fail++; $display("FAIL basic_beat_count: got %0d expected 4", o_beats.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (o_beats[i] !== d[i*32 +: 32]) begin n_fail++; $display("FAIL basic_beat%0d: got %h expected %h", i, o_beats[i], d[i*32 +: 32]); end
        end
        n_cmp++; if (o_first_beat_rel !== 2 || o_wlast_rel !== 5) begin n_fail++; $display("FAIL basic_w_timing: got first=%0d last=%0d expected 2/5", o_first_beat_rel, o_wlast_rel); end
        n_cmp++; if (o_bvalid_abs - o_t0 !== 7) begin n_fail++; $display("FAIL basic_bvalid_cycle: got %0d expected 7", o_bvalid_abs - o_t0); end
        n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL basic_berr: got %b expected 0", o_err); end
    endtask

    task automatic test_aw_stall();
        logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
        logic [31:0]  a = $urandom;
        run_txn(a, d, 2'b00, 3, 0, 0, 1'b0, 0);
        n_cmp++; if (o_aw_cycles !== 4) begin n_fail++; $display("FAIL aw_stall_cycles: got %0d expected 4", o_aw_cycles); end
        n_cmp++; if (o_aw_unstable || o_early_w) begin n_fail++; $display("FAIL aw_stall_protocol: got unstable=%0d early_w=%0d expected 0/0", o_aw_unstable, o_early_w); end
        n_cmp++; if (o_awaddr !== (a & 32'hFFFF_FFF0)) begin n_fail++; $display("FAIL aw_stall_addr: got %h expected %h", o_awaddr, a & 32'hFFFF_FFF0); end
        n_cmp++; if (o_beats.size() !== 4 || o_beats[3] !== d[127:96]) begin n_fail++; $display("FAIL aw_stall_data: got n=%0d last=%h expected 4/%h", o_beats.size(), o_beats[3], d[127:96]); end
    endtask

    task automatic test_w_alternate();
        logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
        bit ok = 1;
        run_txn($urandom, d, 2'b00, 0, 1, 0, 1'b0, 0);
        n_cmp++; if (o_beats.size() !== 4) begin n_fail++; $display("FAIL walt_handshakes: got %0d expected 4", o_beats.size()); end
        n_cmp++; if (o_wlast_cnt !== 1 || o_wlast_beat !== 4) begin n_fail++; $display("FAIL walt_wlast: got cnt=%0d beat=%0d expected 1/4", o_wlast_cnt, o_wlast_beat); end
        n_cmp++; if (o_w_unstable) begin n_fail++; $display("FAIL walt_hold: got unstable=1 expected 0"); end
        for (int i = 0; i < 4; i++) if (o_beats[i] !== d[i*32 +: 32]) ok = 0;
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL walt_data: got %h %h %h %h expected %h", o_beats[0], o_beats[1], o_beats[2], o_beats[3], d); end
    endtask

    task automatic test_slverr();
        run_txn($urandom, {$urandom, $urandom, $urandom, $urandom}, 2'b10, 0, 0, 2, 1'b0, 0);
        n_cmp++; if (o_err !== 1'b1 || o_timeout) begin n_fail++; $display("FAIL slverr_berr: got %b timeout=%0d expected 1/0", o_err, o_timeout); end
        @(negedge clk);
        n_cmp++; if ({bvalid_o, berr_o, awvalid_o, wvalid_o, bready_o} !== 5'b0) begin n_fail++; $display("FAIL slverr_after: got %b expected 00000", {bvalid_o, berr_o, awvalid_o, wvalid_o, bready_o}); end
    endtask

    task automatic test_back_to_back();
        int first_bvalid;
        logic [127:0] d2 = {$urandom, $urandom, $urandom, $urandom};
        run_txn(32'h2000_0000, {4{32'hA5A5_0001}}, 2'b00, 0, 0, 0, 1'b1, 0);
        first_bvalid = o_bvalid_abs;
        n_cmp++; if (o_accepts !== 1) begin n_fail++; $display("FAIL b2b_first_accepts: got %0d expected 1", o_accepts); end
        run_txn(32'h2000_0040, d2, 2'b00, 0, 0, 0, 1'b1, 0);
        wen_i = 1'b0;
        n_cmp++; if (o_accepts !== 1) begin n_fail++; $display("FAIL b2b_second_accepts: got %0d expected 1", o_accepts); end
        n_cmp++; if (o_accept_abs - first_bvalid < 1) begin n_fail++; $display("FAIL b2b_gap: got %0d expected >=1", o_accept_abs - first_bvalid); end
        n_cmp++; if (o_awaddr !== 32'h2000_0040 || o_beats.size() !== 4 || o_beats[0] !== d2[31:0]) begin n_fail++; $display("FAIL b2b_second_txn: got addr=%h n=%0d b0=%h expected 20000040/4/%h", o_awaddr, o_beats.size(), o_beats[0], d2[31:0]); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
        run_txn($urandom, {$urandom, $urandom, $urandom, $urandom}, 2'b00, 0, 0, 0, 1'b0, 2);
        n_cmp++; if (o_post_rst !== 7'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got %b expected 0000000", o_post_rst); end
        run_txn(32'h3000_001C, d, 2'b00, 0, 0, 0, 1'b0, 0);
        n_cmp++; if (o_timeout || o_beats.size() !== 4 || o_beats[0] !== d[31:0] || o_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_recover: got timeout=%0d n=%0d b0=%h err=%b expected 0/4/%h/0", o_timeout, o_beats.size(), o_beats[0], o_err, d[31:0]); end
        n_cmp++; if (o_awaddr !== 32'h3000_0010) begin n_fail++; $display("FAIL rst_mid_addr: got %h expected 30000010", o_awaddr); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
            logic [31:0]  a = $urandom;
            logic [1:0]   r = 2'($urandom_range(0, 3));
            bit ok = 1;
            run_txn(a, d, r, $urandom_range(0, 3), 2, $urandom_range(0, 3), 1'b0, 0);
            for (int i = 0; i < 4; i++) if (o_beats[i] !== d[i*32 +: 32]) ok = 0;
            n_cmp++; if (o_timeout || !ok || o_beats.size() !== 4) begin n_fail++; $display("FAIL rand%0d_data: got timeout=%0d n=%0d ok=%0d expected 0/4/1", t, o_timeout, o_beats.size(), ok); end
            n_cmp++; if (o_awaddr !== (a & 32'hFFFF_FFF0)) begin n_fail++; $display("FAIL rand%0d_addr: got %h expected %h", t, o_awaddr, a & 32'hFFFF_FFF0); end
            n_cmp++; if (o_err !== (r != 2'b00)) begin n_fail++; $display("FAIL rand%0d_berr: got %b expected %b", t, o_err, r != 2'b00); end
            n_cmp++; if (o_accepts !== 1 || o_wlast_cnt !== 1 || o_w_unstable || o_aw_unstable || o_early_w) begin n_fail++; $display("FAIL rand%0d_protocol: got acc=%0d wlast=%0d wu=%0d au=%0d ew=%0d expected 1/1/0/0/0", t, o_accepts, o_wlast_cnt, o_w_unstable, o_aw_unstable, o_early_w); end
        end
    endtask

    initial begin
        rst = 1'b1; wen_i = 1'b0; wdata_i = '0; awaddr_i = '0;
        awready_i = 1'b0; wready_i = 1'b0; bresp_i = 2'b00; bvalid_i = 1'b0;
        test_reset();
        test_basic();
        test_aw_stall();
        test_w_alternate();
        test_slverr();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache_axi_wbridge.md
Name: dcache_axi_wbridge

Overview:
- Memory-side endpoint of the dcache write buffer's request interface.
- Accepts one cache-line write request at a time (wen/wdata/awaddr).
- Issues it as a single AXI4 INCR burst on the AW, W and B channels.
- Returns a one-cycle accept pulse when the request is latched and a one-cycle completion pulse when the B response arrives. Sits between the dcache FIFO and the core's AXI crossbar.

Parameters:
LINE_WIDTH, 128, cache-line bits per request (DCACHELINE_WIDTH)
DATA_WIDTH, 32, AXI data bus width; BEATS = LINE_WIDTH/DATA_WIDTH, power of two, >=2
ADDR_WIDTH, 32, address width
AXI_ID, 1, constant AWID value

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wen_i  in  1  write request valid
wdata_i  in  LINE_WIDTH  line data, beat 0 = bits [DATA_WIDTH-1:0]
awaddr_i  in  ADDR_WIDTH  line address (low bits ignored)
req_accept_o  out  1  one-cycle pulse: request latched
bvalid_o  out  1  one-cycle pulse: write response received
berr_o  out  1  valid with bvalid_o; 1 if BRESP != OKAY
awid_o  out  4  = AXI_ID
awaddr_o  out  ADDR_WIDTH  line-aligned address
awlen_o  out  8  = BEATS-1
awsize_o  out  3  = log2(DATA_WIDTH/8)
awburst_o  out  2  = 2'b01 (INCR)
awvalid_o  out  1  AW valid
awready_i  in  1  AW ready
wdata_o  out  DATA_WIDTH  current beat
wstrb_o  out  DATA_WIDTH/8  all ones
wlast_o  out  1  final beat
wvalid_o  out  1  W valid
wready_i  in  1  W ready
bresp_i  in  2  B response
bvalid_i  in  1  B valid
bready_o  out  1  B ready

Behaviour:
- FSM states: IDLE, ADDR, DATA, RESP. Reset enters IDLE.
- Reset values: req_accept_o, bvalid_o, berr_o, awvalid_o, wvalid_o, wlast_o and bready_o are 0. Beat counter is 0.
- IDLE: when wen_i=1 and bvalid_o=0, at the clock edge:
  - latch awaddr_i with the low log2(LINE_WIDTH/8) bits cleared;
  - latch wdata_i into the beat shift register;
  - go to ADDR and drive req_accept_o=1 for exactly the next cycle.
- wen_i is ignored outside IDLE and in the bvalid_o cycle. The FIFO's wen_i may still be high in the accept cycle and must not cause a second capture.
- ADDR: awvalid_o=1. On awready_i go to DATA. AW address/len are stable while awvalid_o=1.
- DATA: wvalid_o=1 and wdata_o = low DATA_WIDTH bits of the shift register.
  - On each wready_i: shift right by DATA_WIDTH and increment the beat counter.
  - wlast_o=1 when counter == BEATS-1.
  - Handshake on the last beat: counter returns to 0, go to RESP.
  - wdata_o/wlast_o are stable while wvalid_o=1 and wready_i=0.
- RESP: bready_o=1. On bvalid_i, at the edge:
  - bvalid_o=1 for exactly one cycle;
  - berr_o = (bresp_i != 2'b00);
  - go to IDLE.
- The ideal latency with all readies high is: request edge -> accept pulse next cycle -> AW 1 cycle -> W BEATS cycles -> B ≥1 cycle -> bvalid_o. For BEATS=4 with bvalid_i in the first RESP cycle, bvalid_o fires 7 cycles after wen_i is sampled.
- Ordering: bvalid_o never precedes its req_accept_o. At most one transaction is outstanding.
- Error response: berr_o is reported once; the line is not retried. The FIFO still pops it.
- Reset mid-burst: immediate return to IDLE with all valids dropped. This is permitted only under system-wide reset.

Decomposition:
- core_config package: DCACHELINE_WIDTH, AXI_BURST_INCR (2'b01), AXI_RESP_OKAY (2'b00), and the bridge state enum typedef.
- No sub-module is needed. The shift register and beat counter are inline.

Test Plan:
- All readies high, wen_i with awaddr 0x1000_0024 and wdata 128'h44444444_33333333_22222222_11111111 -> req_accept_o at cycle 1, awaddr_o=0x1000_0020, awlen_o=3, wdata beats 0x11111111..0x44444444 in cycles 2-5 with wlast in cycle 5, bvalid_o at cycle 7, berr_o=0.
- awready_i held low 3 cycles -> awvalid_o and awaddr_o stable, no W beats before AW handshake.
- wready_i alternating 0/1 -> each beat held until accepted, exactly 4 handshakes, wlast only on 4th.
- bresp_i=2'b10 (SLVERR) -> bvalid_o=1 with berr_o=1 for one cycle, FSM returns to IDLE.
- Back-to-back requests, wen_i held high through the accept and bvalid_o cycles -> exactly one capture per transaction, second accept no earlier than the cycle after bvalid_o.
- rst asserted during beat 2 -> next cycle all outputs at reset values, a new request then completes normally.
